// File: rtl/ttni_sink_fsm.sv
// -----------------------------------------------------------------------------
// ttni_sink_fsm
//
// Purpose:
//   Receive side of a flit-based message link. Each message is one header flit
//   (traffic id + routing opcode), one body flit carrying the destination port,
//   one body flit carrying a timestamp, then payload body flits closed by a
//   tail flit. Payload words go to a message buffer starting at BASE_WR_ADDR.
//   When the tail arrives the descriptor is presented with o_msg_valid. The
//   sink then holds off new flits until the consumer acknowledges. Malformed
//   traffic raises a one-cycle o_err pulse with a sticky cause code.
//
// Ports:
//   clk              sole clock
//   rst_sink         asynchronous, active-high reset
//   flit             [FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH] type, [FLIT_DATA_WIDTH-1:0] data
//                    type: 01 header, 00 body, 10 tail, 11 illegal
//   valid / ready    flit handshake; a flit is taken when both are high
//   o_wr_en          one-cycle payload write strobe
//   o_wr_addr        payload buffer address (BASE_WR_ADDR + payload index)
//   o_wr_data        payload word
//   o_traffic_id     header data[31:28]
//   o_routing_opcode header data[27:0]
//   o_dest_port_id   first body data[7:0]
//   o_timestamp      second body data[31:0]
//   o_msg_len        number of payload flits including the tail
//   o_msg_valid      a complete message descriptor is being presented
//   i_msg_ack        consumer releases the presented message
//   o_err            one-cycle error pulse
//   o_err_code       cause of the most recent error
//                    1 stray flit, 2 short / abandoned message, 3 overflow or illegal
// -----------------------------------------------------------------------------
module ttni_sink_fsm #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int MSG_MAX         = 1024,
    parameter int BASE_WR_ADDR    = 40,
    localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_sink,
    input  logic [FLIT_WIDTH-1:0]      flit,
    input  logic                       valid,
    output logic                       ready,
    output logic                       o_wr_en,
    output logic [10:0]                o_wr_addr,
    output logic [FLIT_DATA_WIDTH-1:0] o_wr_data,
    output logic [3:0]                 o_traffic_id,
    output logic [27:0]                o_routing_opcode,
    output logic [7:0]                 o_dest_port_id,
    output logic [31:0]                o_timestamp,
    output logic [10:0]                o_msg_len,
    output logic                       o_msg_valid,
    input  logic                       i_msg_ack,
    output logic                       o_err,
    output logic [1:0]                 o_err_code
);

    // Flit type encodings
    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_BODY = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_HDR  = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_TAIL = FLIT_TYPE_WIDTH'(2);
    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_ILL  = FLIT_TYPE_WIDTH'(3);

    // Error cause codes
    localparam logic [1:0] ERR_STRAY = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_DROP  = 2'd3;

    // Counter and address arithmetic is 11 bits wide; the base wraps with it.
    localparam logic [10:0] MSG_MAX_C = 11'(MSG_MAX);
    localparam logic [10:0] BASE_C    = 11'(BASE_WR_ADDR);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PORT    = 3'd1,
        S_TS      = 3'd2,
        S_PAYLOAD = 3'd3,
        S_DONE    = 3'd4,
        S_DROP    = 3'd5
    } state_t;

    state_t                       state;
    logic [10:0]                  count;
    logic [FLIT_TYPE_WIDTH-1:0]   flit_type;
    logic [FLIT_DATA_WIDTH-1:0]   flit_data;
    logic                         accept;
    logic                         in_message;

    assign flit_type = flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
    assign flit_data = flit[FLIT_DATA_WIDTH-1:0];

    // Reset is asynchronous, so ready must drop the moment it is asserted,
    // not at the next edge.
    assign ready  = ~rst_sink & (state != S_DONE);
    assign accept = valid & ready;

    // States in which a header arriving means the current message is cut short.
    assign in_message = (state == S_PORT) || (state == S_TS) || (state == S_PAYLOAD);

    always_ff @(posedge clk or posedge rst_sink) begin
        if (rst_sink) begin
            state            <= S_IDLE;
            count            <= '0;
            o_wr_en          <= 1'b0;
            o_wr_addr        <= '0;
            o_wr_data        <= '0;
            o_traffic_id     <= '0;
            o_routing_opcode <= '0;
            o_dest_port_id   <= '0;
            o_timestamp      <= '0;
            o_msg_len        <= '0;
            o_msg_valid      <= 1'b0;
            o_err            <= 1'b0;
            o_err_code       <= '0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            o_wr_en <= 1'b0;
            o_err   <= 1'b0;

            if (state == S_DONE) begin
                // Descriptor is frozen here because ready is low; only the
                // consumer's acknowledge moves us on.
                if (i_msg_ack) begin
                    o_msg_valid <= 1'b0;
                    state       <= S_IDLE;
                end
            end else if (accept) begin
                if (flit_type == TYPE_HDR) begin
                    // A header always starts a fresh message, whatever we were
                    // doing. Only cutting off a message in flight is an error;
                    // a header that ends a drop is the normal recovery path.
                    o_traffic_id     <= flit_data[31:28];
                    o_routing_opcode <= flit_data[27:0];
                    count            <= '0;
                    state            <= S_PORT;
                    if (in_message) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_SHORT;
                    end
                end else begin
                    case (state)
                        S_IDLE: begin
                            // Body, tail or illegal with no header: discard.
                            o_err      <= 1'b1;
                            o_err_code <= ERR_STRAY;
                        end

                        S_DROP: begin
                            // Silently swallow everything up to the tail.
                            if (flit_type == TYPE_TAIL) begin
                                state <= S_IDLE;
                            end
                        end

                        S_PORT, S_TS: begin
                            if (flit_type == TYPE_ILL) begin
                                o_err      <= 1'b1;
                                o_err_code <= ERR_DROP;
                                state      <= S_DROP;
                            end else if (flit_type == TYPE_TAIL) begin
                                // Tail before any payload slot was reached.
                                o_err      <= 1'b1;
                                o_err_code <= ERR_SHORT;
                                state      <= S_IDLE;
                            end else if (state == S_PORT) begin
                                o_dest_port_id <= flit_data[7:0];
                                state          <= S_TS;
                            end else begin
                                o_timestamp <= flit_data[31:0];
                                state       <= S_PAYLOAD;
                            end
                        end

                        S_PAYLOAD: begin
                            if (flit_type == TYPE_ILL) begin
                                o_err      <= 1'b1;
                                o_err_code <= ERR_DROP;
                                state      <= S_DROP;
                            end else if ((flit_type == TYPE_BODY) && (count == MSG_MAX_C)) begin
                                // Buffer already holds MSG_MAX words; this body
                                // would overrun it, so nothing is written.
                                o_err      <= 1'b1;
                                o_err_code <= ERR_DROP;
                                state      <= S_DROP;
                            end else begin
                                o_wr_en   <= 1'b1;
                                o_wr_addr <= BASE_C + count;
                                o_wr_data <= flit_data;
                                count     <= count + 11'd1;
                                if (flit_type == TYPE_TAIL) begin
                                    // Descriptor becomes visible together with
                                    // the tail's own write.
                                    o_msg_len   <= count + 11'd1;
                                    o_msg_valid <= 1'b1;
                                    state       <= S_DONE;
                                end
                            end
                        end

                        default: begin
                            state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ttni_sink_fsm.sv
// -----------------------------------------------------------------------------
// tb_ttni_sink_fsm
//
// Self-checking bench for ttni_sink_fsm. A message-level reference model
// (header seen / bodies counted since header / dropping / waiting for ack)
// predicts every registered output after each clock edge; a compare process
// checks the DUT against it on every falling edge. Directed sequences pin the
// model with literal expectations, then random flit streams and random
// well-formed messages exercise the rest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ttni_sink_fsm;

    localparam int MSG_MAX = 4;
    localparam int BASE    = 40;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HDR  = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_ILL  = 2'b11;

    logic        clk       = 1'b0;
    logic        rst_sink  = 1'b1;
    logic [33:0] flit      = '0;
    logic        valid     = 1'b0;
    logic        i_msg_ack = 1'b0;

    logic        ready;
    logic        o_wr_en;
    logic [10:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic [3:0]  o_traffic_id;
    logic [27:0] o_routing_opcode;
    logic [7:0]  o_dest_port_id;
    logic [31:0] o_timestamp;
    logic [10:0] o_msg_len;
    logic        o_msg_valid;
    logic        o_err;
    logic [1:0]  o_err_code;

    always #5 clk = ~clk;

    ttni_sink_fsm #(
        .FLIT_DATA_WIDTH (32),
        .FLIT_TYPE_WIDTH (2),
        .MSG_MAX         (MSG_MAX),
        .BASE_WR_ADDR    (BASE)
    ) dut (
        .clk              (clk),
        .rst_sink         (rst_sink),
        .flit             (flit),
        .valid            (valid),
        .ready            (ready),
        .o_wr_en          (o_wr_en),
        .o_wr_addr        (o_wr_addr),
        .o_wr_data        (o_wr_data),
        .o_traffic_id     (o_traffic_id),
        .o_routing_opcode (o_routing_opcode),
        .o_dest_port_id   (o_dest_port_id),
        .o_timestamp      (o_timestamp),
        .o_msg_len        (o_msg_len),
        .o_msg_valid      (o_msg_valid),
        .i_msg_ack        (i_msg_ack),
        .o_err            (o_err),
        .o_err_code       (o_err_code)
    );

    // ---------------------------------------------------------------- counters
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------- reference model
    // Message view: m_active = header taken and message still open,
    // m_nbody = body/tail flits taken since the header (0 -> port, 1 -> ts,
    // n >= 2 -> payload word n-2), m_drop = discarding to the tail,
    // m_done = complete message waiting for ack.
    bit          m_done, m_active, m_drop;
    int          m_nbody;
    logic        e_wr_en, e_valid, e_err;
    logic [10:0] e_addr, e_len;
    logic [31:0] e_data, e_ts;
    logic [3:0]  e_tid;
    logic [27:0] e_opc;
    logic [7:0]  e_port;
    logic [1:0]  e_code;

    task automatic model_reset();
        m_done = 0; m_active = 0; m_drop = 0; m_nbody = 0;
        e_wr_en = 0; e_valid = 0; e_err = 0; e_addr = '0; e_len = '0;
        e_data = '0; e_ts = '0; e_tid = '0; e_opc = '0; e_port = '0; e_code = '0;
    endtask

    task automatic model_err(input logic [1:0] code);
        e_err  = 1'b1;
        e_code = code;
    endtask

    // Called once right after each rising edge with the inputs that edge saw.
    task automatic model_update();
        logic [1:0]  t;
        logic [31:0] d;
        int          idx;
        if (rst_sink) begin
            model_reset();
            return;
        end
        e_wr_en = 0;
        e_err   = 0;
        t = flit[33:32];
        d = flit[31:0];
        if (m_done) begin
            if (i_msg_ack) begin
                m_done  = 0;
                e_valid = 0;
            end
        end else if (valid) begin
            if (t == T_HDR) begin
                if (m_active) model_err(2);
                m_active = 1; m_drop = 0; m_nbody = 0;
                e_tid = d[31:28];
                e_opc = d[27:0];
            end else if (m_drop) begin
                if (t == T_TAIL) m_drop = 0;
            end else if (!m_active) begin
                model_err(1);
            end else if (t == T_ILL) begin
                model_err(3); m_active = 0; m_drop = 1;
            end else if (m_nbody < 2) begin
                if (t == T_TAIL) begin
                    model_err(2); m_active = 0;
                end else begin
                    if (m_nbody == 0) e_port = d[7:0];
                    else              e_ts   = d;
                    m_nbody++;
                end
            end else begin
                idx = m_nbody - 2;
                if (t == T_BODY && idx == MSG_MAX) begin
                    model_err(3); m_active = 0; m_drop = 1;
                end else begin
                    e_wr_en = 1;
                    e_addr  = 11'(BASE + idx);
                    e_data  = d;
                    m_nbody++;
                    if (t == T_TAIL) begin
                        e_len    = 11'(idx + 1);
                        e_valid  = 1;
                        m_done   = 1;
                        m_active = 0;
                    end
                end
            end
        end
    endtask

    // ------------------------------------------------------- compare process
    logic [10:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          err_pulses = 0;
    int          msg_rises  = 0;
    logic        prev_mv    = 1'b0;

    always @(negedge clk) begin
        chk("ready",            64'(ready),            64'(!rst_sink && !m_done));
        chk("o_wr_en",          64'(o_wr_en),          64'(e_wr_en));
        if (e_wr_en) begin
            chk("o_wr_addr",    64'(o_wr_addr),        64'(e_addr));
            chk("o_wr_data",    64'(o_wr_data),        64'(e_data));
        end
        chk("o_msg_valid",      64'(o_msg_valid),      64'(e_valid));
        chk("o_err",            64'(o_err),            64'(e_err));
        chk("o_err_code",       64'(o_err_code),       64'(e_code));
        chk("o_traffic_id",     64'(o_traffic_id),     64'(e_tid));
        chk("o_routing_opcode", 64'(o_routing_opcode), 64'(e_opc));
        chk("o_dest_port_id",   64'(o_dest_port_id),   64'(e_port));
        chk("o_timestamp",      64'(o_timestamp),      64'(e_ts));
        chk("o_msg_len",        64'(o_msg_len),        64'(e_len));
        if (o_wr_en === 1'b1) begin
            wr_addr_q.push_back(o_wr_addr);
            wr_data_q.push_back(o_wr_data);
        end
        if (o_err === 1'b1) err_pulses++;
        if (o_msg_valid === 1'b1 && prev_mv !== 1'b1) begin
            msg_rises++;
            $display("msg   tid=%0d port=%0d len=%0d at %0t", o_traffic_id, o_dest_port_id, o_msg_len, $time);
        end
        prev_mv = o_msg_valid;
    end

    // ------------------------------------------------------------- stimulus
    task automatic step(input logic r, input logic v, input logic [33:0] f, input logic a);
        rst_sink  = r;
        valid     = v;
        flit      = f;
        i_msg_ack = a;
        if (r) model_reset();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] d);
        step(1'b0, 1'b1, {t, d}, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 34'h0, 1'b0);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        err_pulses = 0;
        msg_rises  = 0;
    endtask

    function automatic logic [10:0] q_addr(input int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : 11'bx;
    endfunction

    function automatic logic [31:0] q_data(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'bx;
    endfunction

    // Bound on the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        step(1'b1, 1'b0, 34'h0, 1'b0);
        step(1'b1, 1'b0, 34'h0, 1'b0);
        chk("reset ready", 64'(ready), 64'd0);
        step(1'b0, 1'b0, 34'h0, 1'b0);
        chk("post-reset ready", 64'(ready), 64'd1);

        // Basic message: three payload words.
        clear_logs();
        send(T_HDR,  32'h5000_0ABC);
        send(T_BODY, 32'h0000_0007);
        send(T_BODY, 32'h1234_5678);
        send(T_BODY, 32'h0000_00A0);
        send(T_BODY, 32'h0000_00A1);
        send(T_TAIL, 32'h0000_00A2);
        idle(2);
        chk("basic nwrites", 64'(wr_addr_q.size()), 64'd3);
        chk("basic addr0",   64'(q_addr(0)), 64'd40);
        chk("basic addr1",   64'(q_addr(1)), 64'd41);
        chk("basic addr2",   64'(q_addr(2)), 64'd42);
        chk("basic data0",   64'(q_data(0)), 64'hA0);
        chk("basic data2",   64'(q_data(2)), 64'hA2);
        chk("basic tid",     64'(o_traffic_id), 64'd5);
        chk("basic opcode",  64'(o_routing_opcode), 64'hABC);
        chk("basic port",    64'(o_dest_port_id), 64'd7);
        chk("basic ts",      64'(o_timestamp), 64'h1234_5678);
        chk("basic len",     64'(o_msg_len), 64'd3);
        chk("basic mvalid",  64'(o_msg_valid), 64'd1);

        // Back-pressure while the message awaits its ack.
        send(T_HDR, 32'h9000_0001);
        send(T_HDR, 32'h9000_0001);
        chk("done ready",    64'(ready), 64'd0);
        chk("done tid held", 64'(o_traffic_id), 64'd5);
        step(1'b0, 1'b1, {T_HDR, 32'h9000_0001}, 1'b1);
        chk("ack mvalid",    64'(o_msg_valid), 64'd0);
        chk("ack ready",     64'(ready), 64'd1);
        chk("ack tid",       64'(o_traffic_id), 64'd5);
        send(T_HDR, 32'h9000_0001);
        chk("hdr2 tid",      64'(o_traffic_id), 64'd9);

        // Short message: header, port, tail.
        clear_logs();
        send(T_BODY, 32'h0000_0022);
        send(T_TAIL, 32'h0000_0033);
        idle(2);
        chk("short err pulses", 64'(err_pulses), 64'd1);
        chk("short code",       64'(o_err_code), 64'd2);
        chk("short nwrites",    64'(wr_addr_q.size()), 64'd0);
        chk("short mvalid",     64'(msg_rises), 64'd0);

        // Stray tail in idle.
        clear_logs();
        send(T_TAIL, 32'h0000_0055);
        idle(2);
        chk("stray err pulses", 64'(err_pulses), 64'd1);
        chk("stray code",       64'(o_err_code), 64'd1);
        chk("stray nwrites",    64'(wr_addr_q.size()), 64'd0);

        // Overflow: five payload bodies with room for four.
        clear_logs();
        send(T_HDR,  32'h3000_0001);
        send(T_BODY, 32'h0000_0001);
        send(T_BODY, 32'h0000_0002);
        for (int i = 0; i < 5; i++) send(T_BODY, 32'h0000_00B0 + 32'(i));
        send(T_BODY, 32'h0000_00B5);
        send(T_TAIL, 32'h0000_00BF);
        idle(2);
        chk("ovf nwrites",    64'(wr_addr_q.size()), 64'd4);
        chk("ovf addr0",      64'(q_addr(0)), 64'd40);
        chk("ovf addr3",      64'(q_addr(3)), 64'd43);
        chk("ovf data3",      64'(q_data(3)), 64'hB3);
        chk("ovf err pulses", 64'(err_pulses), 64'd1);
        chk("ovf code",       64'(o_err_code), 64'd3);
        chk("ovf mvalid",     64'(msg_rises), 64'd0);
        send(T_BODY, 32'h0000_0077);
        idle(1);
        chk("after drop code", 64'(o_err_code), 64'd1);

        // Reset in the middle of the payload.
        send(T_HDR,  32'h2000_0002);
        send(T_BODY, 32'h0000_0004);
        send(T_BODY, 32'h0000_0005);
        send(T_BODY, 32'h0000_00C0);
        send(T_BODY, 32'h0000_00C1);
        step(1'b1, 1'b0, 34'h0, 1'b0);
        chk("mid-rst ready", 64'(ready), 64'd0);
        chk("mid-rst tid",   64'(o_traffic_id), 64'd0);
        chk("mid-rst wr_en", 64'(o_wr_en), 64'd0);
        chk("mid-rst code",  64'(o_err_code), 64'd0);
        step(1'b1, 1'b0, 34'h0, 1'b0);
        step(1'b0, 1'b0, 34'h0, 1'b0);
        clear_logs();
        send(T_HDR,  32'h6000_0006);
        send(T_BODY, 32'h0000_0009);
        send(T_BODY, 32'h0000_1111);
        send(T_BODY, 32'h0000_00D0);
        send(T_BODY, 32'h0000_00D1);
        send(T_TAIL, 32'h0000_00D2);
        idle(2);
        chk("post-rst addr0", 64'(q_addr(0)), 64'd40);
        chk("post-rst n",     64'(wr_addr_q.size()), 64'd3);
        chk("post-rst len",   64'(o_msg_len), 64'd3);
        step(1'b0, 1'b0, 34'h0, 1'b1);

        // Random flit soup, occasional resets.
        for (int i = 0; i < 2500; i++) begin
            int          x;
            logic [1:0]  t;
            x = int'($urandom_range(0, 19));
            if (x < 3)       t = T_HDR;
            else if (x < 15) t = T_BODY;
            else if (x < 19) t = T_TAIL;
            else             t = T_ILL;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 {t, 32'($urandom)}, ($urandom_range(0, 2) == 0));
        end
        step(1'b0, 1'b0, 34'h0, 1'b1);

        // Random well-formed messages with gaps, some too long.
        for (int m = 0; m < 150; m++) begin
            int n;
            n = int'($urandom_range(0, MSG_MAX + 1));
            send(T_HDR, 32'($urandom));
            if ($urandom_range(0, 1) == 1) idle(1);
            send(T_BODY, 32'($urandom));
            send(T_BODY, 32'($urandom));
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(T_BODY, 32'($urandom));
            end
            send(T_TAIL, 32'($urandom));
            for (int w = 0; w < 20 && m_done; w++)
                step(1'b0, 1'b0, 34'h0, ($urandom_range(0, 2) == 0) || (w == 19));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
